// File: rtl/score_counter_if.sv
// Request/status bundle for the two-digit BCD score counter.
// The master drives the request pulses and the slave returns the score and status.
interface score_counter_if;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       clr_pulse;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic       armed;
  logic       at_max;
  logic       at_min;
  logic       changed;

  modport master (
    output inc_pulse, dec_pulse, clr_pulse,
    input  score_tens, score_ones, armed, at_max, at_min, changed
  );

  modport slave (
    input  inc_pulse, dec_pulse, clr_pulse,
    output score_tens, score_ones, armed, at_max, at_min, changed
  );
endinterface

// File: rtl/score_counter.sv
// Two-digit BCD up/down score counter.
// A clear takes effect only when a second clr pulse arrives within CLR_WINDOW cycles of the first.
module score_counter #(
  parameter int WRAP       = 1,
  parameter int CLR_WINDOW = 50000000
) (
  input  logic           clk,
  input  logic           reset,
  score_counter_if.slave bus
);

  localparam int CW = $clog2(CLR_WINDOW + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  localparam logic [CW-1:0] WIN_LAST = CW'(CLR_WINDOW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          changed_q, changed_d;

  logic [7:0]    score_s;
  logic [7:0]    next_score_s;
  logic [7:0]    stepped_s;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99) begin
      r = (WRAP != 0) ? 8'h00 : 8'h99;
    end else if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h00) begin
      r = (WRAP != 0) ? 8'h99 : 8'h00;
    end else if (s[3:0] == 4'd0) begin
      r = {s[7:4] - 4'd1, 4'd9};
    end else begin
      r = {s[7:4], s[3:0] - 4'd1};
    end
    return r;
  endfunction

  assign score_s = {tens_q, ones_q};

  // Score after applying inc/dec alone; inc and dec together cancel.
  always_comb begin
    stepped_s = score_s;
    if (bus.inc_pulse && !bus.dec_pulse) begin
      stepped_s = bcd_inc(score_s);
    end else if (bus.dec_pulse && !bus.inc_pulse) begin
      stepped_s = bcd_dec(score_s);
    end else begin
      stepped_s = score_s;
    end
  end

  // Clear-confirm FSM and next-score selection; clr outranks inc/dec in both states.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    next_score_s = score_s;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_pulse) begin
          state_d = ST_ARMED;
          cnt_d   = CNT_ONE;
        end else begin
          next_score_s = stepped_s;
        end
      end
      ST_ARMED: begin
        if (bus.clr_pulse) begin
          state_d      = ST_IDLE;
          cnt_d        = CNT_ZERO;
          next_score_s = 8'h00;
        end else if (bus.inc_pulse || bus.dec_pulse) begin
          state_d      = ST_IDLE;
          cnt_d        = CNT_ZERO;
          next_score_s = stepped_s;
        end else if (cnt_q >= WIN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    tens_d    = next_score_s[7:4];
    ones_d    = next_score_s[3:0];
    changed_d = (next_score_s != score_s);
  end

  // State, window counter, score digits and change pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      changed_q <= changed_d;
    end
  end

  assign bus.score_tens = tens_q;
  assign bus.score_ones = ones_q;
  assign bus.armed      = (state_q == ST_ARMED);
  assign bus.changed    = changed_q;
  assign bus.at_max     = (score_s == 8'h99);
  assign bus.at_min     = (score_s == 8'h00);

endmodule

// File: tb/tb_score_counter.sv
// Randomised and directed bench for score_counter, one wrapping and one saturating instance,
// both checked each cycle against a decimal model that tracks the clear window by elapsed cycles.
module tb_score_counter;

  localparam int WIN = 8;

  logic clk;
  logic reset;

  score_counter_if ifw ();
  score_counter_if ifs ();

  score_counter #(.WRAP(1), .CLR_WINDOW(WIN)) dut_w (.clk(clk), .reset(reset), .bus(ifw));
  score_counter #(.WRAP(0), .CLR_WINDOW(WIN)) dut_s (.clk(clk), .reset(reset), .bus(ifs));

  int n_checks = 0;
  int n_errors = 0;
  int chg_cnt_w = 0;

  // Reference model state: decimal scores, arming time and cycle count
  int sw, ss;
  bit armed_m;
  int arm_cyc, cyc;
  bit exp_armed, exp_chg_w, exp_chg_s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int score_of_w();
    return int'(ifw.score_tens) * 10 + int'(ifw.score_ones);
  endfunction

  function automatic int score_of_s();
    return int'(ifs.score_tens) * 10 + int'(ifs.score_ones);
  endfunction

  task automatic model_reset();
    sw = 0; ss = 0; armed_m = 1'b0; arm_cyc = 0;
    exp_armed = 1'b0; exp_chg_w = 1'b0; exp_chg_s = 1'b0;
  endtask

  task automatic model_apply(input bit i, input bit d, input bit c);
    int old_w, old_s;
    bit live;
    old_w = sw;
    old_s = ss;
    live = armed_m && ((cyc - arm_cyc) <= WIN);
    if (c) begin
      if (live) begin
        sw = 0; ss = 0; armed_m = 1'b0;
      end else begin
        armed_m = 1'b1; arm_cyc = cyc;
      end
    end else if (i || d) begin
      armed_m = 1'b0;
      if (i && !d) begin
        sw = (sw + 1) % 100;
        ss = (ss == 99) ? 99 : ss + 1;
      end else if (d && !i) begin
        sw = (sw + 99) % 100;
        ss = (ss == 0) ? 0 : ss - 1;
      end
    end
    cyc++;
    exp_armed = armed_m && ((cyc - arm_cyc) <= WIN);
    exp_chg_w = (sw != old_w);
    exp_chg_s = (ss != old_s);
  endtask

  task automatic drive(input bit i, input bit d, input bit c);
    ifw.inc_pulse = i; ifw.dec_pulse = d; ifw.clr_pulse = c;
    ifs.inc_pulse = i; ifs.dec_pulse = d; ifs.clr_pulse = c;
  endtask

  task automatic step(input bit i, input bit d, input bit c);
    drive(i, d, c);
    @(posedge clk);
    model_apply(i, d, c);
    #1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_score", score_of_w(), 0);
    chk("async_rst_armed", int'(ifw.armed), 0);
    chk("async_rst_at_min", int'(ifs.at_min), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("w_score", score_of_w(), sw);
      chk("s_score", score_of_s(), ss);
      chk("w_digits_bcd", int'(ifw.score_tens <= 4'd9 && ifw.score_ones <= 4'd9), 1);
      chk("s_digits_bcd", int'(ifs.score_tens <= 4'd9 && ifs.score_ones <= 4'd9), 1);
      chk("w_armed", int'(ifw.armed), int'(exp_armed));
      chk("s_armed", int'(ifs.armed), int'(exp_armed));
      chk("w_changed", int'(ifw.changed), int'(exp_chg_w));
      chk("s_changed", int'(ifs.changed), int'(exp_chg_s));
      chk("w_at_max", int'(ifw.at_max), int'(sw == 99));
      chk("w_at_min", int'(ifw.at_min), int'(sw == 0));
      chk("s_at_max", int'(ifs.at_max), int'(ss == 99));
      chk("s_at_min", int'(ifs.at_min), int'(ss == 0));
      if (ifw.changed) chg_cnt_w++;
    end
  end

  initial begin
    cyc = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    chk("rst_score", score_of_w(), 0);
    chk("rst_at_min", int'(ifw.at_min), 1);
    chk("rst_at_max", int'(ifw.at_max), 0);
    chk("rst_armed", int'(ifw.armed), 0);
    chk("rst_changed", int'(ifw.changed), 0);

    // Count up through 99 and wrap / saturate
    chg_cnt_w = 0;
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 98) chk("lit_at_max_99", int'(ifw.at_max), 1);
    end
    chk("lit_wrap_00", {ifw.score_tens, ifw.score_ones}, 8'h00);
    chk("lit_sat_99", {ifs.score_tens, ifs.score_ones}, 8'h99);
    chk("lit_sat_nochg", int'(ifs.changed), 0);
    @(negedge clk);
    #1;
    chk("count_up_changed", chg_cnt_w, 100);

    // Decrement below 00
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    chk("lit_wrap_99", {ifw.score_tens, ifw.score_ones}, 8'h99);
    chk("lit_sat_00", {ifs.score_tens, ifs.score_ones}, 8'h00);
    chk("lit_sat00_nochg", int'(ifs.changed), 0);

    // Second clr at the last cycle of the window clears
    do_reset();
    repeat (42) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (WIN - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("lit_clear_00", {ifw.score_tens, ifw.score_ones}, 8'h00);
    chk("lit_clear_chg", int'(ifw.changed), 1);
    chk("lit_clear_armed", int'(ifw.armed), 0);

    // One cycle late: times out, then re-arms
    repeat (42) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (WIN) step(1'b0, 1'b0, 1'b0);
    chk("lit_timeout_armed", int'(ifw.armed), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("lit_rearm", int'(ifw.armed), 1);
    chk("lit_rearm_42", {ifw.score_tens, ifw.score_ones}, 8'h42);

    // Disarm and simultaneous requests
    do_reset();
    repeat (42) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("lit_disarm", int'(ifw.armed), 0);
    chk("lit_disarm_43", {ifw.score_tens, ifw.score_ones}, 8'h43);
    step(1'b1, 1'b1, 1'b0);
    chk("lit_incdec_43", {ifw.score_tens, ifw.score_ones}, 8'h43);
    chk("lit_incdec_nochg", int'(ifw.changed), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("lit_clrinc_armed", int'(ifw.armed), 1);
    chk("lit_clrinc_43", {ifw.score_tens, ifw.score_ones}, 8'h43);

    // Digit carry and borrow
    do_reset();
    repeat (9) step(1'b1, 1'b0, 1'b0);
    chk("lit_09", {ifw.score_tens, ifw.score_ones}, 8'h09);
    step(1'b1, 1'b0, 1'b0);
    chk("lit_10", {ifw.score_tens, ifw.score_ones}, 8'h10);
    step(1'b0, 1'b1, 1'b0);
    chk("lit_back_09", {ifw.score_tens, ifw.score_ones}, 8'h09);

    // Reset while armed at 57
    do_reset();
    repeat (57) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("lit_57_armed", int'(ifw.armed), 1);
    chk("lit_57", {ifw.score_tens, ifw.score_ones}, 8'h57);
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    chk("lit_post_rst_arm", int'(ifw.armed), 1);
    chk("lit_post_rst_00", {ifw.score_tens, ifw.score_ones}, 8'h00);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit ri, rd, rc;
      if (n % 700 == 699) do_reset();
      ri = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        ri = 1'b0; rd = 1'b0;
      end
      step(ri, rd, rc);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
